// File: rtl/ycfsm_pkg.sv
// Shared dual-rail codes, lane state type and helpers for the Y-cell lane array.
package ycfsm_pkg;

   // Dual-rail code points
   localparam logic [1:0] EMPTY   = 2'b00;
   localparam logic [1:0] ZERO    = 2'b01;
   localparam logic [1:0] ONE     = 2'b10;
   localparam logic [1:0] ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HOLD = 2'b01,
      ERR  = 2'b10
   } lane_state_e;

   // True for any code other than ILLEGAL
   function automatic logic dr_legal(input logic [1:0] code);
      return code != ILLEGAL;
   endfunction

endpackage

// File: rtl/ycfsm_lane.sv
// One Y-cell lane: matches a dual-rail input against a dual-rail match value,
// holds the result until the input returns to empty, and flags illegal codes.
module ycfsm_lane
   import ycfsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       lane_clr,
   input  logic [1:0] in_dr,
   input  logic [1:0] match_dr,
   output logic [1:0] out_dr,
   output logic       err,
   output logic       hold_nx_c,
   output logic       idle_nx_c,
   output logic       err_entry_c
);

   lane_state_e state_q, state_d;
   logic [1:0]  out_q, out_d;
   logic        err_q, err_d;

   // Next state, latched result and ERR-entry pulse
   always_comb begin
      state_d     = state_q;
      out_d       = EMPTY;
      err_entry_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (!dr_legal(in_dr) || !dr_legal(match_dr)) begin
               state_d = ERR;
            end else if (in_dr != EMPTY && match_dr != EMPTY) begin
               state_d = HOLD;
               out_d   = (in_dr == match_dr) ? ONE : ZERO;
            end
         end
         HOLD: begin
            // Result is frozen; only empty or illegal input ends the hold
            if (in_dr == ILLEGAL) begin
               state_d = ERR;
            end else if (in_dr == EMPTY) begin
               state_d = IDLE;
            end else begin
               out_d = out_q;
            end
         end
         ERR: begin
            if (in_dr == EMPTY && dr_legal(match_dr)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A lane clear beats any transition and suppresses the ERR entry
      if (lane_clr) begin
         state_d = IDLE;
         out_d   = EMPTY;
      end

      err_d       = (state_d == ERR);
      err_entry_c = (state_d == ERR) && (state_q != ERR);
      hold_nx_c   = (state_d == HOLD);
      idle_nx_c   = (state_d == IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         out_q   <= EMPTY;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

   assign out_dr = out_q;
   assign err    = err_q;

endmodule

// File: rtl/ycfsm_lanes.sv
// NCH independent Y-cell lanes with aggregate completion flags and a
// saturating count of ERR entries.
module ycfsm_lanes
   import ycfsm_pkg::*;
#(
   parameter int unsigned NCH  = 8,
   parameter int unsigned CNTW = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2*NCH-1:0]  in,
   input  logic [2*NCH-1:0]  match,
   input  logic [NCH-1:0]    lane_clr,
   output logic [2*NCH-1:0]  out,
   output logic              all_valid,
   output logic              all_empty,
   output logic [NCH-1:0]    err_lane,
   output logic [CNTW-1:0]   err_count
);

   localparam int unsigned SUMW = $clog2(NCH + 1);
   localparam int unsigned ACCW = ((CNTW > SUMW) ? CNTW : SUMW) + 1;
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic [NCH-1:0]  hold_nx;
   logic [NCH-1:0]  idle_nx;
   logic [NCH-1:0]  err_entry;

   logic            all_valid_q, all_valid_d;
   logic            all_empty_q, all_empty_d;
   logic [CNTW-1:0] err_count_q, err_count_d;
   logic [SUMW-1:0] n_entry_c;
   logic [ACCW-1:0] sum_c;

   for (genvar g = 0; g < NCH; g++) begin : g_lane
      ycfsm_lane u_lane (
         .clk         (clk),
         .reset       (reset),
         .lane_clr    (lane_clr[g]),
         .in_dr       (in[2*g +: 2]),
         .match_dr    (match[2*g +: 2]),
         .out_dr      (out[2*g +: 2]),
         .err         (err_lane[g]),
         .hold_nx_c   (hold_nx[g]),
         .idle_nx_c   (idle_nx[g]),
         .err_entry_c (err_entry[g])
      );
   end

   // Aggregate flags from next lane states, plus popcount and saturating add
   always_comb begin
      all_valid_d = &hold_nx;
      all_empty_d = &idle_nx;
      n_entry_c   = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         n_entry_c = n_entry_c + SUMW'(err_entry[i]);
      end
      sum_c = ACCW'(err_count_q) + ACCW'(n_entry_c);
      if (sum_c > ACCW'(CNT_MAX)) begin
         err_count_d = CNT_MAX;
      end else begin
         err_count_d = CNTW'(sum_c);
      end
   end

   // Flag and counter registers; err_count is cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         all_valid_q <= 1'b0;
         all_empty_q <= 1'b1;
         err_count_q <= '0;
      end else begin
         all_valid_q <= all_valid_d;
         all_empty_q <= all_empty_d;
         err_count_q <= err_count_d;
      end
   end

   assign all_valid = all_valid_q;
   assign all_empty = all_empty_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_ycfsm_lanes.sv
// Directed bench for ycfsm_lanes: an 8-lane instance with an 8-bit counter and
// an 8-lane instance with a 2-bit counter share the same stimulus.
`timescale 1ns/1ps
module tb_ycfsm_lanes;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_v;
   logic [15:0] match_v;
   logic [7:0]  lane_clr;

   logic [15:0] out1, out2;
   logic        av1, ae1, av2, ae2;
   logic [7:0]  el1, el2;
   logic [7:0]  cnt1;
   logic [1:0]  cnt2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ycfsm_lanes #(.NCH(8), .CNTW(8)) u_dut (
      .clk(clk), .reset(reset), .in(in_v), .match(match_v), .lane_clr(lane_clr),
      .out(out1), .all_valid(av1), .all_empty(ae1), .err_lane(el1), .err_count(cnt1)
   );

   ycfsm_lanes #(.NCH(8), .CNTW(2)) u_dut2 (
      .clk(clk), .reset(reset), .in(in_v), .match(match_v), .lane_clr(lane_clr),
      .out(out2), .all_valid(av2), .all_empty(ae2), .err_lane(el2), .err_count(cnt2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_v = '0; match_v = '0; lane_clr = '0;
      tick();
      tick();
      n_vec++; if (out1 !== 16'h0000) begin n_err++; $display("FAIL reset out: got %h want %h", out1, 16'h0000); end
      n_vec++; if (ae1 !== 1'b1) begin n_err++; $display("FAIL reset all_empty: got %b want 1", ae1); end
      n_vec++; if (av1 !== 1'b0) begin n_err++; $display("FAIL reset all_valid: got %b want 0", av1); end
      n_vec++; if (el1 !== 8'h00) begin n_err++; $display("FAIL reset err_lane: got %h want 00", el1); end
      n_vec++; if (cnt1 !== 8'd0) begin n_err++; $display("FAIL reset err_count: got %0d want 0", cnt1); end
      n_vec++; if (cnt2 !== 2'd0) begin n_err++; $display("FAIL reset err_count2: got %0d want 0", cnt2); end
      reset = 1'b0;
      tick();
      n_vec++; if (ae1 !== 1'b1) begin n_err++; $display("FAIL idle all_empty: got %b want 1", ae1); end
   endtask

   task automatic test_all_match();
      in_v = 16'h5555; match_v = 16'h5555;
      tick();
      n_vec++; if (out1 !== 16'hAAAA) begin n_err++; $display("FAIL all_match out: got %h want %h", out1, 16'hAAAA); end
      n_vec++; if (av1 !== 1'b1) begin n_err++; $display("FAIL all_match all_valid: got %b want 1", av1); end
      n_vec++; if (ae1 !== 1'b0) begin n_err++; $display("FAIL all_match all_empty: got %b want 0", ae1); end
      tick();
      n_vec++; if (out1 !== 16'hAAAA) begin n_err++; $display("FAIL all_match hold out: got %h want %h", out1, 16'hAAAA); end
      in_v = 16'h0000;
      tick();
      n_vec++; if (out1 !== 16'h0000) begin n_err++; $display("FAIL all_match rte out: got %h want 0000", out1); end
      n_vec++; if (ae1 !== 1'b1 || av1 !== 1'b0) begin n_err++; $display("FAIL all_match rte flags: got ae=%b av=%b want ae=1 av=0", ae1, av1); end
      // even lanes match ZERO with ZERO -> ONE, odd lanes ZERO vs ONE -> ZERO
      in_v = 16'h5555; match_v = 16'h9999;
      tick();
      n_vec++; if (out1 !== 16'h6666) begin n_err++; $display("FAIL mixed out: got %h want %h", out1, 16'h6666); end
      n_vec++; if (av1 !== 1'b1) begin n_err++; $display("FAIL mixed all_valid: got %b want 1", av1); end
      in_v = 16'h0000; match_v = 16'h0000;
      tick();
   endtask

   task automatic test_mismatch_hold();
      in_v = 16'h0002; match_v = 16'h0001;
      tick();
      n_vec++; if (out1 !== 16'h0001) begin n_err++; $display("FAIL mismatch out: got %h want 0001", out1); end
      n_vec++; if (av1 !== 1'b0 || ae1 !== 1'b0) begin n_err++; $display("FAIL mismatch flags: got av=%b ae=%b want av=0 ae=0", av1, ae1); end
      match_v = 16'h0002;
      tick();
      n_vec++; if (out1 !== 16'h0001) begin n_err++; $display("FAIL match change ignored: got %h want 0001", out1); end
      in_v = 16'h0001;
      tick();
      n_vec++; if (out1 !== 16'h0001) begin n_err++; $display("FAIL in change ignored: got %h want 0001", out1); end
      in_v = 16'h0000;
      tick();
      n_vec++; if (out1 !== 16'h0000) begin n_err++; $display("FAIL mismatch rte out: got %h want 0000", out1); end
      n_vec++; if (ae1 !== 1'b1) begin n_err++; $display("FAIL mismatch rte all_empty: got %b want 1", ae1); end
      match_v = 16'h0000;
      tick();
   endtask

   task automatic test_errors();
      in_v = 16'h0C30;  // lanes 2 and 5 ILLEGAL
      tick();
      n_vec++; if (el1 !== 8'h24) begin n_err++; $display("FAIL err lanes: got %h want 24", el1); end
      n_vec++; if (cnt1 !== 8'd2) begin n_err++; $display("FAIL err double count: got %0d want 2", cnt1); end
      n_vec++; if (out1 !== 16'h0000 || ae1 !== 1'b0) begin n_err++; $display("FAIL err out/ae: got %h/%b want 0000/0", out1, ae1); end
      tick();
      n_vec++; if (cnt1 !== 8'd2) begin n_err++; $display("FAIL err steady count: got %0d want 2", cnt1); end
      in_v = 16'h0000;
      tick();
      n_vec++; if (el1 !== 8'h00) begin n_err++; $display("FAIL err exit: got %h want 00", el1); end
      n_vec++; if (ae1 !== 1'b1) begin n_err++; $display("FAIL err exit all_empty: got %b want 1", ae1); end
   endtask

   task automatic test_saturate();
      in_v = 16'h000F;  // lanes 0,1 -> 4 total, 2-bit counter saturates at 3
      tick();
      n_vec++; if (cnt1 !== 8'd4) begin n_err++; $display("FAIL sat count8: got %0d want 4", cnt1); end
      n_vec++; if (cnt2 !== 2'd3) begin n_err++; $display("FAIL sat count2 a: got %0d want 3", cnt2); end
      in_v = 16'h0000; tick();
      in_v = 16'h0003; tick();
      n_vec++; if (cnt1 !== 8'd5 || cnt2 !== 2'd3) begin n_err++; $display("FAIL sat 5th entry: got %0d/%0d want 5/3", cnt1, cnt2); end
      in_v = 16'h0000; tick();
      // illegal match with empty input enters ERR and keeps the lane there
      match_v = 16'h0003;
      tick();
      n_vec++; if (el1 !== 8'h01 || cnt1 !== 8'd6) begin n_err++; $display("FAIL match illegal: got %h/%0d want 01/6", el1, cnt1); end
      tick();
      n_vec++; if (el1 !== 8'h01) begin n_err++; $display("FAIL err stay on bad match: got %h want 01", el1); end
      match_v = 16'h0000;
      tick();
      n_vec++; if (el1 !== 8'h00) begin n_err++; $display("FAIL err leave: got %h want 00", el1); end
      in_v = 16'hFFFF;
      tick();
      n_vec++; if (el1 !== 8'hFF || cnt1 !== 8'd14) begin n_err++; $display("FAIL eight entries: got %h/%0d want ff/14", el1, cnt1); end
      n_vec++; if (cnt2 !== 2'd3) begin n_err++; $display("FAIL sat count2 b: got %0d want 3", cnt2); end
      in_v = 16'h0000;
      tick();
   endtask

   task automatic test_lane_clr();
      in_v = 16'h0080; match_v = 16'h0080;  // lane 3 ONE vs ONE
      tick();
      n_vec++; if (out1 !== 16'h0080) begin n_err++; $display("FAIL clr pre out: got %h want 0080", out1); end
      lane_clr = 8'h08;
      tick();
      n_vec++; if (out1 !== 16'h0000 || ae1 !== 1'b1) begin n_err++; $display("FAIL clr idle: got %h/%b want 0000/1", out1, ae1); end
      lane_clr = 8'h00;
      tick();
      n_vec++; if (out1 !== 16'h0080) begin n_err++; $display("FAIL clr restore: got %h want 0080", out1); end
      // lane 3 goes illegal while being cleared: no ERR entry
      in_v = 16'h00C0; lane_clr = 8'h08;
      tick();
      n_vec++; if (el1 !== 8'h00 || cnt1 !== 8'd14) begin n_err++; $display("FAIL clr suppress: got %h/%0d want 00/14", el1, cnt1); end
      lane_clr = 8'h00;
      tick();
      n_vec++; if (el1 !== 8'h08 || cnt1 !== 8'd15) begin n_err++; $display("FAIL post clr err: got %h/%0d want 08/15", el1, cnt1); end
      in_v = 16'h0000; match_v = 16'h0000;
      tick();
   endtask

   task automatic test_reset_mid();
      in_v = 16'h5555; match_v = 16'h5555;
      tick();
      n_vec++; if (av1 !== 1'b1) begin n_err++; $display("FAIL mid pre all_valid: got %b want 1", av1); end
      reset = 1'b1;
      tick();
      n_vec++; if (out1 !== 16'h0000 || ae1 !== 1'b1 || av1 !== 1'b0) begin n_err++; $display("FAIL mid reset: got %h ae=%b av=%b want 0000 ae=1 av=0", out1, ae1, av1); end
      n_vec++; if (cnt1 !== 8'd0 || cnt2 !== 2'd0) begin n_err++; $display("FAIL mid reset count: got %0d/%0d want 0/0", cnt1, cnt2); end
      reset = 1'b0;
      tick();
      n_vec++; if (out1 !== 16'hAAAA) begin n_err++; $display("FAIL post reset rematch: got %h want aaaa", out1); end
      in_v = 16'h0000; match_v = 16'h0000;
      tick();
   endtask

   initial begin
      test_reset();
      test_all_match();
      test_mismatch_hold();
      test_errors();
      test_saturate();
      test_lane_clr();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
